// File: rtl/snitch_perf_sampler.sv
// Performance-counter sampler: snapshots counters on a periodic or software trigger and streams masked
// entries through a sample FIFO. Define SNITCH_PERF_SAMPLER_TIMESTAMP_EN to attach a 48-bit round timestamp.
module snitch_perf_sampler #(
  parameter int unsigned NumCounters  = 16,
  parameter int unsigned CounterWidth = 48,
  parameter int unsigned FifoDepth    = 8
) (
  input  logic                                      clk_i,
  input  logic                                      rst_i,
  input  logic                                      enable_i,
  input  logic [31:0]                               interval_i,
  input  logic                                      trigger_i,
  input  logic [NumCounters-1:0]                    counter_mask_i,
  input  logic [NumCounters-1:0][CounterWidth-1:0]  counter_i,
  output logic                                      sample_valid_o,
  input  logic                                      sample_ready_i,
  output logic [((NumCounters > 1) ? $clog2(NumCounters) : 1)-1:0] sample_idx_o,
  output logic [CounterWidth-1:0]                   sample_data_o,
  output logic                                      sample_last_o,
  output logic [47:0]                               sample_ts_o,
  output logic                                      busy_o,
  output logic                                      overrun_o,
  input  logic                                      clear_overrun_i
);

  localparam int unsigned IdxW = (NumCounters > 1) ? $clog2(NumCounters) : 1;
  localparam int unsigned PtrW = (FifoDepth > 1) ? $clog2(FifoDepth) : 1;
  localparam logic [PtrW:0] FullCnt = (PtrW+1)'(FifoDepth);

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT,
    S_SCAN
  } state_e;

  state_e                                 r_state;
  logic [31:0]                            r_timer;
  logic [NumCounters-1:0][CounterWidth-1:0] r_shadow;
  logic [NumCounters-1:0]                 r_pend;
  logic                                   r_overrun;

  logic [PtrW-1:0]                        r_wr_ptr;
  logic [PtrW-1:0]                        r_rd_ptr;
  logic [PtrW:0]                          r_count;
  logic [CounterWidth-1:0]                r_mem_data [FifoDepth];
  logic [IdxW-1:0]                        r_mem_idx  [FifoDepth];
  logic                                   r_mem_last [FifoDepth];

  logic                                   w_timer_on;
  logic                                   w_tc;
  logic                                   w_trig;
  logic                                   w_full;
  logic                                   w_pop;
  logic                                   w_push;
  logic [IdxW-1:0]                        w_sel_idx;
  logic [NumCounters-1:0]                 w_sel_oh;
  logic                                   w_sel_last;
  logic [CounterWidth-1:0]                w_sel_data;

  // Trigger qualification and FIFO handshake
  assign w_timer_on = (r_state != S_IDLE) && (interval_i != 32'd0);
  assign w_tc       = w_timer_on && (r_timer >= (interval_i - 32'd1));
  assign w_trig     = (trigger_i | w_tc) && (counter_mask_i != '0);
  assign w_full     = (r_count == FullCnt);
  assign w_pop      = sample_valid_o && sample_ready_i;
  assign w_push     = (r_state == S_SCAN) && enable_i && (!w_full || w_pop);

  // Lowest pending index is the next entry of the round
  always_comb begin
    w_sel_idx = '0;
    for (int i = int'(NumCounters) - 1; i >= 0; i--) begin
      if (r_pend[i]) w_sel_idx = IdxW'(i);
    end
  end

  assign w_sel_oh   = r_pend & (~r_pend + NumCounters'(1));
  assign w_sel_last = ((r_pend & ~w_sel_oh) == '0);
  assign w_sel_data = r_shadow[w_sel_idx];

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state   <= S_IDLE;
      r_timer   <= 32'd0;
      r_shadow  <= '0;
      r_pend    <= '0;
      r_overrun <= 1'b0;
      r_wr_ptr  <= '0;
      r_rd_ptr  <= '0;
      r_count   <= '0;
    end else begin
      if ((r_state == S_SCAN) && w_trig) begin
        r_overrun <= 1'b1;
      end else if (clear_overrun_i) begin
        r_overrun <= 1'b0;
      end

      if (!enable_i || !w_timer_on || w_tc) begin
        r_timer <= 32'd0;
      end else begin
        r_timer <= r_timer + 32'd1;
      end

      case (r_state)
        S_IDLE: begin
          if (enable_i) r_state <= S_WAIT;
        end
        S_WAIT: begin
          if (!enable_i) begin
            r_state <= S_IDLE;
          end else if (w_trig) begin
            r_shadow <= counter_i;
            r_pend   <= counter_mask_i;
            r_state  <= S_SCAN;
          end
        end
        S_SCAN: begin
          if (!enable_i) begin
            r_state <= S_IDLE;
            r_pend  <= '0;
          end else if (w_push) begin
            r_pend <= r_pend & ~w_sel_oh;
            if (w_sel_last) r_state <= S_WAIT;
          end
        end
        default: r_state <= S_IDLE;
      endcase

      // Leaving for IDLE drops everything still queued
      if (!enable_i) begin
        r_wr_ptr <= '0;
        r_rd_ptr <= '0;
        r_count  <= '0;
      end else begin
        if (w_push) r_wr_ptr <= r_wr_ptr + PtrW'(1);
        if (w_pop)  r_rd_ptr <= r_rd_ptr + PtrW'(1);
        r_count <= r_count + (PtrW+1)'(w_push) - (PtrW+1)'(w_pop);
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (w_push) begin
      r_mem_data[r_wr_ptr] <= w_sel_data;
      r_mem_idx[r_wr_ptr]  <= w_sel_idx;
      r_mem_last[r_wr_ptr] <= w_sel_last;
    end
  end

  assign sample_valid_o = (r_count != '0);
  assign sample_idx_o   = sample_valid_o ? r_mem_idx[r_rd_ptr]  : '0;
  assign sample_data_o  = sample_valid_o ? r_mem_data[r_rd_ptr] : '0;
  assign sample_last_o  = sample_valid_o ? r_mem_last[r_rd_ptr] : 1'b0;
  assign busy_o         = (r_state == S_SCAN);
  assign overrun_o      = r_overrun;

`ifdef SNITCH_PERF_SAMPLER_TIMESTAMP_EN
  logic [47:0] r_ts;
  logic [47:0] r_ts_shadow;
  logic [47:0] r_mem_ts [FifoDepth];

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_ts        <= 48'd0;
      r_ts_shadow <= 48'd0;
    end else begin
      r_ts <= r_ts + 48'd1;
      if ((r_state == S_WAIT) && enable_i && w_trig) r_ts_shadow <= r_ts;
    end
  end

  always_ff @(posedge clk_i) begin
    if (w_push) r_mem_ts[r_wr_ptr] <= r_ts_shadow;
  end

  assign sample_ts_o = sample_valid_o ? r_mem_ts[r_rd_ptr] : 48'd0;
`else
  assign sample_ts_o = 48'd0;
`endif

endmodule

// File: tb/tb_snitch_perf_sampler.sv
// Directed bench for snitch_perf_sampler with a queue-based reference model checked every cycle.
module tb_snitch_perf_sampler;

  logic              clk;
  logic              rst;
  logic              enable;
  logic [31:0]       interval;
  logic              trigger;
  logic [15:0]       mask;
  logic [15:0][47:0] cnt;
  logic              valid;
  logic              ready;
  logic [3:0]        idx;
  logic [47:0]       data;
  logic              last;
  logic [47:0]       ts;
  logic              busy;
  logic              overrun;
  logic              clr;

  int checks = 0;
  int errors = 0;

  snitch_perf_sampler dut (
    .clk_i           (clk),
    .rst_i           (rst),
    .enable_i        (enable),
    .interval_i      (interval),
    .trigger_i       (trigger),
    .counter_mask_i  (mask),
    .counter_i       (cnt),
    .sample_valid_o  (valid),
    .sample_ready_i  (ready),
    .sample_idx_o    (idx),
    .sample_data_o   (data),
    .sample_last_o   (last),
    .sample_ts_o     (ts),
    .busy_o          (busy),
    .overrun_o       (overrun),
    .clear_overrun_i (clr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference model: a round is a list of entries built at trigger time, drained into a bounded queue
  typedef struct packed {
    logic [3:0]  idx;
    logic [47:0] data;
    logic        last;
    logic [47:0] ts;
  } ent_t;

  ent_t  m_fifo[$];
  ent_t  m_round[$];
  int    m_mode;          // 0 idle, 1 waiting, 2 scanning
  int    m_mode_q;
  logic [31:0] m_timer;
  logic [47:0] m_ts;
  logic  m_ovr;
  logic  m_on, m_tc, m_trig, m_pop, m_push;
  int    m_hi;
  ent_t  m_e;
  bit    m_chk_en = 1'b0;

  always @(posedge clk) begin
    if (rst) begin
      m_mode  = 0;
      m_timer = 32'd0;
      m_ts    = 48'd0;
      m_ovr   = 1'b0;
      m_fifo.delete();
      m_round.delete();
    end else begin
      m_mode_q = m_mode;
      m_on   = (m_mode_q != 0) && (interval != 32'd0);
      m_tc   = m_on && (m_timer >= interval - 32'd1);
      m_trig = (trigger || m_tc) && (mask != 16'd0);
      m_pop  = (m_fifo.size() != 0) && ready;
      m_push = (m_mode_q == 2) && enable && ((m_fifo.size() < 8) || m_pop);
      if ((m_mode_q == 2) && m_trig) m_ovr = 1'b1;
      else if (clr) m_ovr = 1'b0;
      if (m_pop) void'(m_fifo.pop_front());
      if (m_push) begin
        m_fifo.push_back(m_round.pop_front());
        if (m_round.size() == 0) m_mode = 1;
      end
      if ((m_mode_q == 1) && enable && m_trig) begin
        m_hi = -1;
        for (int i = 0; i < 16; i++) if (mask[i]) m_hi = i;
        for (int i = 0; i < 16; i++) begin
          if (mask[i]) begin
            m_e.idx  = 4'(i);
            m_e.data = cnt[i];
            m_e.last = (i == m_hi);
            m_e.ts   = m_ts;
            m_round.push_back(m_e);
          end
        end
        m_mode = 2;
      end
      if ((m_mode_q == 0) && enable) m_mode = 1;
      if (!enable) begin
        m_mode = 0;
        m_fifo.delete();
        m_round.delete();
      end
      if (!enable || !m_on || m_tc) m_timer = 32'd0;
      else m_timer = m_timer + 32'd1;
      m_ts = m_ts + 48'd1;
    end
  end

  always @(negedge clk) begin
    if (m_chk_en) begin
      chk("valid", 64'(valid), 64'(m_fifo.size() != 0));
      chk("busy", 64'(busy), 64'(m_mode == 2));
      chk("overrun", 64'(overrun), 64'(m_ovr));
      if (m_fifo.size() != 0) begin
        chk("idx", 64'(idx), 64'(m_fifo[0].idx));
        chk("data", 64'(data), 64'(m_fifo[0].data));
        chk("last", 64'(last), 64'(m_fifo[0].last));
`ifdef SNITCH_PERF_SAMPLER_TIMESTAMP_EN
        chk("ts", 64'(ts), 64'(m_fifo[0].ts));
`else
        chk("ts", 64'(ts), 64'd0);
`endif
      end
    end
  end

  logic [3:0]  r_idx  [16];
  logic [47:0] r_data [16];
  logic        r_last [16];
  logic [47:0] r_ts   [16];
  int          r_k    [16];
  int          nrec;

  initial begin
    rst = 1'b1; enable = 1'b0; interval = 32'd0; trigger = 1'b0;
    mask = 16'd0; ready = 1'b0; clr = 1'b0;
    for (int i = 0; i < 16; i++) cnt[i] = 48'h100000 + 48'(i);
    tick();
    m_chk_en = 1'b1;
    tick();
    tick();
    chk("rst_valid", 64'(valid), 64'd0);
    chk("rst_idx", 64'(idx), 64'd0);
    chk("rst_data", 64'(data), 64'd0);
    chk("rst_last", 64'(last), 64'd0);
    chk("rst_ts", 64'(ts), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_overrun", 64'(overrun), 64'd0);
    rst = 1'b0;

    // Empty mask: trigger has no effect
    enable = 1'b1;
    tick();
    trigger = 1'b1;
    tick();
    trigger = 1'b0;
    tick(); tick();
    chk("mask0_busy", 64'(busy), 64'd0);
    chk("mask0_valid", 64'(valid), 64'd0);
    chk("mask0_overrun", 64'(overrun), 64'd0);

    // Full mask with consumer stalled, then drained
    mask = 16'hFFFF;
    trigger = 1'b1;
    tick();
    trigger = 1'b0;
    for (int i = 0; i < 16; i++) cnt[i] = 48'hFFFF00 + 48'(i);
    chk("t1_busy", 64'(busy), 64'd1);
    chk("t1_valid", 64'(valid), 64'd0);
    tick();
    chk("t2_valid", 64'(valid), 64'd1);
    chk("t2_idx", 64'(idx), 64'd0);
    chk("t2_data", 64'(data), 64'h100000);
    repeat (10) tick();
    chk("stall_busy", 64'(busy), 64'd1);
    chk("stall_idx", 64'(idx), 64'd0);
    trigger = 1'b1;
    tick();
    trigger = 1'b0;
    chk("ovr_set", 64'(overrun), 64'd1);
    clr = 1'b1;
    tick();
    clr = 1'b0;
    chk("ovr_clear", 64'(overrun), 64'd0);
    trigger = 1'b1; clr = 1'b1;
    tick();
    trigger = 1'b0; clr = 1'b0;
    chk("ovr_set_wins", 64'(overrun), 64'd1);
    clr = 1'b1;
    tick();
    clr = 1'b0;
    chk("ovr_clear2", 64'(overrun), 64'd0);
    ready = 1'b1;
    nrec = 0;
    for (int k = 0; k < 60 && nrec < 16; k++) begin
      if (valid) begin
        r_idx[nrec] = idx; r_data[nrec] = data; r_last[nrec] = last; r_ts[nrec] = ts;
        nrec++;
      end
      tick();
    end
    chk("drain_count", 64'(nrec), 64'd16);
    for (int i = 0; i < 16 && i < nrec; i++) begin
      chk("drain_idx", 64'(r_idx[i]), 64'(i));
      chk("drain_data", 64'(r_data[i]), 64'h100000 + 64'(i));
      chk("drain_last", 64'(r_last[i]), 64'(i == 15));
      chk("drain_ts_same", 64'(r_ts[i]), 64'(r_ts[0]));
    end
    chk("drain_busy", 64'(busy), 64'd0);

    // Disable with entries queued flushes everything
    ready = 1'b0;
    trigger = 1'b1;
    tick();
    trigger = 1'b0;
    repeat (3) tick();
    chk("q3_valid", 64'(valid), 64'd1);
    chk("q3_busy", 64'(busy), 64'd1);
    enable = 1'b0;
    tick();
    chk("flush_valid", 64'(valid), 64'd0);
    chk("flush_busy", 64'(busy), 64'd0);

    // Periodic timer every 10 cycles, mask 0x5
    interval = 32'd10;
    mask = 16'h0005;
    ready = 1'b1;
    for (int i = 0; i < 16; i++) cnt[i] = 48'h2000 + 48'(i);
    tick();
    enable = 1'b1;
    nrec = 0;
    for (int k = 1; k <= 35; k++) begin
      tick();
      if (valid && nrec < 4) begin
        r_k[nrec] = k; r_idx[nrec] = idx; r_data[nrec] = data; r_last[nrec] = last;
        nrec++;
      end
    end
    chk("per_count", 64'(nrec), 64'd4);
    if (nrec == 4) begin
      chk("per_k0", 64'(r_k[0]), 64'd12);
      chk("per_k1", 64'(r_k[1]), 64'd13);
      chk("per_k2", 64'(r_k[2]), 64'd22);
      chk("per_k3", 64'(r_k[3]), 64'd23);
      chk("per_idx0", 64'(r_idx[0]), 64'd0);
      chk("per_idx1", 64'(r_idx[1]), 64'd2);
      chk("per_last0", 64'(r_last[0]), 64'd0);
      chk("per_last1", 64'(r_last[1]), 64'd1);
      chk("per_data1", 64'(r_data[1]), 64'h2002);
      chk("per_idx2", 64'(r_idx[2]), 64'd0);
      chk("per_last3", 64'(r_last[3]), 64'd1);
    end

    enable = 1'b0;
    tick();
    tick();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/snitch_perf_sampler.md
SNITCH_PERF_SAMPLER -- requirements
Module: snitch_perf_sampler

Interface
REQ-001 SHALL have parameter NumCounters, default 16: number of performance counters sampled.
REQ-002 SHALL have parameter CounterWidth, default 48: width of each counter value.
REQ-003 SHALL have parameter FifoDepth, default 8 (power of two, >=2): sample FIFO entries.
REQ-004 SHALL have port clk_i  in  1  single clock; one clock, reset synchronous active-high.
REQ-005 SHALL have port rst_i  in  1  synchronous active-high reset.
REQ-006 SHALL have port enable_i  in  1  sampler enable level.
REQ-007 SHALL have port interval_i  in  32  trigger period in cycles; 0 = periodic timer off.
REQ-008 SHALL have port trigger_i  in  1  single-cycle software sample request.
REQ-009 SHALL have port counter_mask_i  in  NumCounters  counters included in a round.
REQ-010 SHALL have port counter_i  in  NumCounters x CounterWidth  live counter values.
REQ-011 SHALL have port sample_valid_o  out  1  FIFO head valid.
REQ-012 SHALL have port sample_ready_i  in  1  consumer accepts head.
REQ-013 SHALL have port sample_idx_o  out  $clog2(NumCounters)  counter index of head.
REQ-014 SHALL have port sample_data_o  out  CounterWidth  snapshot value of head.
REQ-015 SHALL have port sample_last_o  out  1  head is last entry of its round.
REQ-016 SHALL have port sample_ts_o  out  48  round timestamp of head.
REQ-017 SHALL have ports busy_o out 1 (round in progress), overrun_o out 1 (sticky), clear_overrun_i in 1.

Function
REQ-018 SHALL implement FSM IDLE, WAIT, SCAN; IDLE->WAIT when enable_i=1; any state->IDLE next edge when enable_i=0.
REQ-019 SHALL run a 32-bit timer in WAIT/SCAN counting 0..interval_i-1 and wrapping; timer terminal count is a periodic trigger; timer held at 0 in IDLE or when interval_i=0.
REQ-020 Trigger = trigger_i OR periodic trigger; SHALL be ignored when counter_mask_i=0.
REQ-021 On trigger in WAIT at cycle t: SHALL capture all counter_i and counter_mask_i into shadow registers at end of t and enter SCAN at t+1.
REQ-022 In SCAN SHALL push one masked shadow entry per cycle, ascending index, when FIFO not full; stall (no drop) while full.
REQ-023 First entry SHALL appear on sample_valid_o at t+2; FIFO output registered, handshake fires when valid&ready.
REQ-024 sample_valid_o, once high, SHALL hold idx/data/last/ts stable until accepted.
REQ-025 sample_last_o SHALL be 1 only on the highest masked index of the round; after pushing it FSM SHALL return to WAIT.
REQ-026 Trigger while in SCAN SHALL be dropped and set overrun_o at next edge.
REQ-027 clear_overrun_i SHALL clear overrun_o; simultaneous set and clear: set wins.
REQ-028 Simultaneous push and pop on full FIFO SHALL be permitted (occupancy unchanged).
REQ-029 Transition to IDLE SHALL flush FIFO and abandon any partial round.
REQ-030 busy_o SHALL be 1 exactly while in SCAN.
REQ-031 Changes to counter_mask_i during SCAN SHALL not affect the current round.

Reset
REQ-032 On rst_i: state IDLE, timer 0, FIFO empty, shadows 0, timestamp counter 0.
REQ-033 Reset outputs: sample_valid_o=0, sample_idx_o=0, sample_data_o=0, sample_last_o=0, sample_ts_o=0, busy_o=0, overrun_o=0.
REQ-034 Reset mid-round SHALL discard all pending entries with no further output.

Configuration
REQ-035 Macro SNITCH_PERF_SAMPLER_TIMESTAMP_EN defined: free-running 48-bit cycle counter (wrapping) captured at trigger, carried with every entry of the round on sample_ts_o.
REQ-036 Macro undefined: no timestamp counter or FIFO storage for it; sample_ts_o tied to 0.

Verification
REQ-037 interval_i=10, mask=0x5, counters constant, ready=1 -> every 10 cycles entries idx 0 then idx 2 (last=1); first valid 2 cycles after trigger.
REQ-038 trigger_i pulse, mask=0xFFFF, ready=0 -> 8 entries buffered, SCAN stalls, busy_o=1; ready=1 -> all 16 delivered in order, last on idx 15.
REQ-039 second trigger during stalled SCAN -> overrun_o=1, round count unchanged; clear_overrun_i -> overrun_o=0 next cycle.
REQ-040 enable_i=0 mid-round with 3 entries queued -> next cycle valid=0, busy_o=0, IDLE.
REQ-041 counter_i changes after trigger -> delivered data equals values at trigger cycle; with TIMESTAMP_EN, all entries of round share identical sample_ts_o.
REQ-042 mask=0 with trigger_i -> no entries, busy_o stays 0, overrun_o stays 0.
